// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues in-order imem reads and buffers {pc, inst}
// in a DEPTH-entry FIFO for decode. Define IFQ_BYPASS_EN to pass a response straight to decode when empty.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redir,
   input  logic        rel,
   input  logic [31:0] br_pc,
   input  logic [31:0] diff,
   input  logic [31:0] nxt,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = AW + 3;

   logic [31:0]   faddr_q, faddr_d;
   logic [31:0]   rpc_q, rpc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];

   logic [SW-1:0] inflight;
   logic [31:0]   target;
   logic          fire;
   logic          resp_drop;
   logic          resp_keep;
   logic          push;
   logic          pop;
   logic          byp_take;

   // Buffered, outstanding and to-be-dropped entries together never exceed DEPTH.
   assign inflight       = SW'(cnt_q) + SW'(outst_q) + SW'(drop_q);
   assign imem_req_valid = !rst && !redir && (inflight < SW'(DEPTH));
   assign imem_req_addr  = faddr_q;
   assign fire           = imem_req_valid && imem_req_ready;

   assign resp_drop = imem_resp_valid && (drop_q != '0);
   assign resp_keep = imem_resp_valid && (drop_q == '0) && (outst_q != '0);
   assign target    = (rel ? (br_pc + diff) : nxt) & 32'hFFFF_FFFC;

`ifdef IFQ_BYPASS_EN
   logic byp_show;

   assign byp_show  = resp_keep && (cnt_q == '0) && !redir;
   assign byp_take  = byp_show && out_ready;
   assign out_valid = (cnt_q != '0) || byp_show;
   assign out_pc    = (cnt_q != '0) ? pc_mem_q[rptr_q]   : rpc_q;
   assign out_inst  = (cnt_q != '0) ? inst_mem_q[rptr_q] : imem_resp_data;
`else
   assign byp_take  = 1'b0;
   assign out_valid = (cnt_q != '0);
   assign out_pc    = pc_mem_q[rptr_q];
   assign out_inst  = inst_mem_q[rptr_q];
`endif

   assign push = resp_keep && !byp_take;
   assign pop  = (cnt_q != '0) && out_ready;

   always_comb begin
      faddr_d = faddr_q;
      rpc_d   = rpc_q;
      outst_d = outst_q;
      drop_d  = drop_q;
      cnt_d   = cnt_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      if (redir) begin
         // Every response still owed for a pre-redirect request gets discarded,
         // including one arriving right now.
         faddr_d = target;
         rpc_d   = target;
         outst_d = '0;
         drop_d  = drop_q + outst_q - CW'(resp_drop || resp_keep);
         cnt_d   = '0;
         rptr_d  = wptr_q;
      end else begin
         if (fire)      faddr_d = faddr_q + 32'd4;
         if (resp_keep) rpc_d   = rpc_q + 32'd4;
         if (resp_drop) drop_d  = drop_q - CW'(1);
         outst_d = outst_q + CW'(fire) - CW'(resp_keep);
         cnt_d   = cnt_q + CW'(push) - CW'(pop);
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         faddr_q <= RESET_PC;
         rpc_q   <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
         cnt_q   <= '0;
         rptr_q  <= '0;
         wptr_q  <= '0;
      end else begin
         faddr_q <= faddr_d;
         rpc_q   <= rpc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !redir) begin
         pc_mem_q[wptr_q]   <= rpc_q;
         inst_mem_q[wptr_q] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order memory model with variable latency, and a reference stream model
// (after reset/redirect the popped PCs run target, target+4, ... with inst = memf(pc)).
`timescale 1ns/1ps
module tb_ifetch_queue;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst, redir, rel;
   logic [31:0] br_pc, diff, nxt;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_inst;

   int errors = 0;
   int checks = 0;

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .redir(redir), .rel(rel), .br_pc(br_pc), .diff(diff), .nxt(nxt),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
   endfunction

   int          cyc = 0;
   int          last_due = 0;
   int          lat_min = 1, lat_max = 1;
   bit          rnd = 1'b0;
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] pop_pc[$], pop_inst[$], pop_exp[$];
   int          pop_cyc[$];
   logic [31:0] fire_addr[$], fire_exp[$];
   int          fire_cyc[$];
   logic [31:0] exp_pop, exp_req;
   logic        s_req_valid, s_out_valid;
   logic [31:0] s_req_addr, s_out_pc, s_out_inst;

   task automatic clear_obs();
      pop_pc.delete(); pop_inst.delete(); pop_exp.delete(); pop_cyc.delete();
      fire_addr.delete(); fire_exp.delete(); fire_cyc.delete();
   endtask

   // One clock: sample at negedge, update the models, then drive next-cycle inputs just after posedge.
   task automatic tick();
      logic [31:0] t;
      int lat;
      @(negedge clk);
      s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
      s_out_valid = out_valid; s_out_pc = out_pc; s_out_inst = out_inst;
      if (rst) begin
         exp_pop = RST_PC;
         exp_req = RST_PC;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            lat = $urandom_range(lat_max, lat_min);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            mq_addr.push_back(imem_req_addr); mq_due.push_back(last_due);
            fire_addr.push_back(imem_req_addr); fire_exp.push_back(exp_req); fire_cyc.push_back(cyc);
            exp_req += 32'd4;
         end
         if (redir) begin
            t = rel ? br_pc + diff : nxt;
            t[1:0] = 2'b00;
            exp_pop = t;
            exp_req = t;
         end else if (out_valid && out_ready) begin
            pop_pc.push_back(out_pc); pop_inst.push_back(out_inst);
            pop_exp.push_back(exp_pop); pop_cyc.push_back(cyc);
            exp_pop += 32'd4;
         end
      end
      @(posedge clk); #1;
      cyc++;
      redir = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data = 32'h0;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data = memf(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (rnd) begin
         imem_req_ready = ($urandom_range(99, 0) < 70);
         out_ready = ($urandom_range(99, 0) < 75);
         if ($urandom_range(99, 0) < 6) begin
            redir = 1'b1; rel = 1'($urandom_range(1, 0));
            br_pc = $urandom; diff = $urandom; nxt = $urandom;
         end
      end
   endtask

   task automatic quiesce();
      redir = 1'b0; imem_req_ready = 1'b0; out_ready = 1'b1;
      repeat (8) tick();
   endtask

   task automatic test_reset();
      clear_obs();
      rst = 1'b1; imem_req_ready = 1'b1; out_ready = 1'b1; lat_min = 1; lat_max = 1;
      repeat (3) begin
         tick();
         checks++;
         if (s_out_valid !== 1'b0 || s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs out_valid=%b req_valid=%b required 0/0", s_out_valid, s_req_valid);
         end
      end
      rst = 1'b0;
      imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
      repeat (12) tick();
      checks++;
      if (fire_addr.size() < 1 || fire_addr[0] !== RST_PC) begin
         errors++; $display("FAIL first_fetch addr=%h required %h", fire_addr[0], RST_PC);
      end
`ifdef IFQ_BYPASS_EN
      checks++;
      if (pop_pc.size() != 11 || pop_cyc[0] - fire_cyc[0] != 1) begin
         errors++; $display("FAIL stream_rate pops=%0d lat=%0d required 11/1", pop_pc.size(), pop_cyc[0] - fire_cyc[0]);
      end
`else
      checks++;
      if (pop_pc.size() != 10 || pop_cyc[0] - fire_cyc[0] != 2) begin
         errors++; $display("FAIL stream_rate pops=%0d lat=%0d required 10/2", pop_pc.size(), pop_cyc[0] - fire_cyc[0]);
      end
`endif
      checks++;
      if (pop_pc[0] !== 32'hFFFF_FFF8 || pop_pc[1] !== 32'hFFFF_FFFC || pop_pc[2] !== 32'h0) begin
         errors++; $display("FAIL wrap_seq pcs=%h,%h,%h required fffffff8,fffffffc,00000000", pop_pc[0], pop_pc[1], pop_pc[2]);
      end
      for (int i = 0; i < pop_pc.size(); i++) begin
         checks++;
         if (pop_pc[i] !== pop_exp[i] || pop_inst[i] !== memf(pop_exp[i])) begin
            errors++; $display("FAIL reset_pop[%0d] pc=%h inst=%h required %h/%h", i, pop_pc[i], pop_inst[i], pop_exp[i], memf(pop_exp[i]));
         end
      end
   endtask

   task automatic test_backpressure();
      int f0;
      clear_obs();
      imem_req_ready = 1'b1; out_ready = 1'b1; redir = 1'b1; rel = 1'b0; nxt = 32'h0;
      tick();
      out_ready = 1'b0; lat_min = 1; lat_max = 3;
      repeat (20) tick();
      checks++;
      if (fire_addr.size() != DEPTH || s_req_valid !== 1'b0) begin
         errors++; $display("FAIL cap_requests fires=%0d req_valid=%b required %0d/0", fire_addr.size(), s_req_valid, DEPTH);
      end
      checks++;
      if (s_out_valid !== 1'b1 || s_out_pc !== 32'h0 || s_out_inst !== memf(32'h0)) begin
         errors++; $display("FAIL held_head v=%b pc=%h inst=%h required 1/0/%h", s_out_valid, s_out_pc, s_out_inst, memf(32'h0));
      end
      f0 = fire_addr.size();
      out_ready = 1'b1;
      repeat (12) tick();
      checks++;
      if (pop_pc.size() < 4 || pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8 || pop_pc[3] !== 32'hC) begin
         errors++; $display("FAIL drain_order n=%0d pcs=%h,%h,%h,%h required 0,4,8,c", pop_pc.size(), pop_pc[0], pop_pc[1], pop_pc[2], pop_pc[3]);
      end
      checks++;
      if (fire_addr.size() <= f0 || fire_addr[f0] !== 32'h10) begin
         errors++; $display("FAIL resume_fetch addr=%h required 00000010", fire_addr[f0]);
      end
      for (int i = 0; i < pop_pc.size(); i++) begin
         checks++;
         if (pop_pc[i] !== pop_exp[i] || pop_inst[i] !== memf(pop_exp[i])) begin
            errors++; $display("FAIL bp_pop[%0d] pc=%h inst=%h required %h/%h", i, pop_pc[i], pop_inst[i], pop_exp[i], memf(pop_exp[i]));
         end
      end
   endtask

   task automatic test_abs_redirect();
      int f0;
      quiesce();
      clear_obs();
      out_ready = 1'b0; redir = 1'b1; rel = 1'b0; nxt = 32'h80;
      tick();
      imem_req_ready = 1'b1; lat_min = 1; lat_max = 1;
      tick();
      lat_min = 4; lat_max = 4;
      tick();
      tick();
      imem_req_ready = 1'b0;
      tick();
      checks++;
      if (fire_addr.size() != 3 || s_out_valid !== 1'b1 || s_out_pc !== 32'h80) begin
         errors++; $display("FAIL abs_setup fires=%0d v=%b pc=%h required 3/1/80", fire_addr.size(), s_out_valid, s_out_pc);
      end
      f0 = fire_addr.size();
      redir = 1'b1; rel = 1'b0; nxt = 32'h100; out_ready = 1'b1;
      tick();
      checks++;
      if (s_req_valid !== 1'b0) begin
         errors++; $display("FAIL abs_redir_noreq req_valid=%b required 0", s_req_valid);
      end
      imem_req_ready = 1'b1; lat_min = 1; lat_max = 1;
      repeat (12) tick();
      checks++;
      if (pop_pc.size() < 2 || pop_pc[0] !== 32'h100 || pop_pc[1] !== 32'h104 || fire_addr[f0] !== 32'h100) begin
         errors++; $display("FAIL abs_redirect pcs=%h,%h fetch=%h required 100,104/100", pop_pc[0], pop_pc[1], fire_addr[f0]);
      end
      for (int i = 0; i < pop_pc.size(); i++) begin
         checks++;
         if (pop_pc[i] !== pop_exp[i] || pop_inst[i] !== memf(pop_exp[i])) begin
            errors++; $display("FAIL abs_pop[%0d] pc=%h inst=%h required %h/%h", i, pop_pc[i], pop_inst[i], pop_exp[i], memf(pop_exp[i]));
         end
      end
   endtask

   task automatic test_rel_redirect();
      int n, p0, f0;
      quiesce();
      clear_obs();
      imem_req_ready = 1'b1; out_ready = 1'b1; lat_min = 1; lat_max = 1;
      repeat (4) tick();
      n = 0;
      while (!imem_resp_valid && n < 20) begin
         tick(); n++;
      end
      checks++;
      if (imem_resp_valid !== 1'b1) begin
         errors++; $display("FAIL rel_wait_resp no response within 20 cycles, required one");
      end
      p0 = pop_pc.size(); f0 = fire_addr.size();
      redir = 1'b1; rel = 1'b1; br_pc = 32'h20; diff = 32'hFFFF_FFF0;
      tick();
      checks++;
      if (s_req_valid !== 1'b0) begin
         errors++; $display("FAIL rel_redir_noreq req_valid=%b required 0", s_req_valid);
      end
      repeat (8) tick();
      checks++;
      if (pop_pc.size() <= p0 || pop_pc[p0] !== 32'h10 || pop_inst[p0] !== memf(32'h10) || fire_addr[f0] !== 32'h10) begin
         errors++; $display("FAIL rel_target pc=%h inst=%h fetch=%h required 10/%h/10", pop_pc[p0], pop_inst[p0], fire_addr[f0], memf(32'h10));
      end
      p0 = pop_pc.size(); f0 = fire_addr.size();
      redir = 1'b1; rel = 1'b0; nxt = 32'h103;
      tick();
      repeat (8) tick();
      checks++;
      if (fire_addr.size() <= f0 || fire_addr[f0] !== 32'h100 || pop_pc[p0] !== 32'h100) begin
         errors++; $display("FAIL align_target fetch=%h pc=%h required 100/100", fire_addr[f0], pop_pc[p0]);
      end
      for (int i = 0; i < pop_pc.size(); i++) begin
         checks++;
         if (pop_pc[i] !== pop_exp[i] || pop_inst[i] !== memf(pop_exp[i])) begin
            errors++; $display("FAIL rel_pop[%0d] pc=%h inst=%h required %h/%h", i, pop_pc[i], pop_inst[i], pop_exp[i], memf(pop_exp[i]));
         end
      end
   endtask

   task automatic test_midreset();
      int p0, f0;
      quiesce();
      clear_obs();
      out_ready = 1'b0; imem_req_ready = 1'b1; lat_min = 1; lat_max = 1;
      tick();
      lat_min = 4; lat_max = 4;
      repeat (3) tick();
      checks++;
      if (s_out_valid !== 1'b1 || fire_addr.size() != 4) begin
         errors++; $display("FAIL midrst_setup v=%b fires=%0d required 1/4", s_out_valid, fire_addr.size());
      end
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (s_out_valid !== 1'b0 || s_req_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_clear v=%b req_valid=%b required 0/0", s_out_valid, s_req_valid);
      end
      repeat (3) tick();
      rst = 1'b0; out_ready = 1'b1; lat_min = 1; lat_max = 1;
      if (!imem_resp_valid) begin
         imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
      end
      p0 = pop_pc.size(); f0 = fire_addr.size();
      repeat (8) tick();
      checks++;
      if (fire_addr.size() <= f0 || fire_addr[f0] !== RST_PC || pop_pc.size() <= p0 || pop_pc[p0] !== RST_PC) begin
         errors++; $display("FAIL midrst_restart fetch=%h pc=%h required %h/%h", fire_addr[f0], pop_pc[p0], RST_PC, RST_PC);
      end
      for (int i = 0; i < pop_pc.size(); i++) begin
         checks++;
         if (pop_pc[i] !== pop_exp[i] || pop_inst[i] !== memf(pop_exp[i])) begin
            errors++; $display("FAIL midrst_pop[%0d] pc=%h inst=%h required %h/%h", i, pop_pc[i], pop_inst[i], pop_exp[i], memf(pop_exp[i]));
         end
      end
   endtask

`ifdef IFQ_BYPASS_EN
   task automatic test_bypass();
      logic [31:0] a;
      quiesce();
      clear_obs();
      out_ready = 1'b1; imem_req_ready = 1'b1; lat_min = 1; lat_max = 1;
      tick();
      imem_req_ready = 1'b0;
      a = fire_addr[0];
      imem_resp_data = 32'h0000_0013;
      tick();
      checks++;
      if (s_out_valid !== 1'b1 || s_out_inst !== 32'h13 || s_out_pc !== a) begin
         errors++; $display("FAIL bypass_same_cycle v=%b inst=%h pc=%h required 1/13/%h", s_out_valid, s_out_inst, s_out_pc, a);
      end
      tick();
      checks++;
      if (s_out_valid !== 1'b0) begin
         errors++; $display("FAIL bypass_no_fill out_valid=%b required 0", s_out_valid);
      end
      clear_obs();
   endtask
`endif

   task automatic test_random();
      quiesce();
      clear_obs();
      lat_min = 1; lat_max = 3; rnd = 1'b1;
      repeat (400) tick();
      rnd = 1'b0;
      quiesce();
      checks++;
      if (pop_pc.size() < 50) begin
         errors++; $display("FAIL random_progress pops=%0d required >=50", pop_pc.size());
      end
      for (int i = 0; i < fire_addr.size(); i++) begin
         checks++;
         if (fire_addr[i] !== fire_exp[i]) begin
            errors++; $display("FAIL random_fetch[%0d] addr=%h required %h", i, fire_addr[i], fire_exp[i]);
         end
      end
      for (int i = 0; i < pop_pc.size(); i++) begin
         checks++;
         if (pop_pc[i] !== pop_exp[i] || pop_inst[i] !== memf(pop_exp[i])) begin
            errors++; $display("FAIL random_pop[%0d] pc=%h inst=%h required %h/%h", i, pop_pc[i], pop_inst[i], pop_exp[i], memf(pop_exp[i]));
         end
      end
   endtask

   initial begin
      rst = 1'b1; redir = 1'b0; rel = 1'b0; br_pc = 32'h0; diff = 32'h0; nxt = 32'h0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; out_ready = 1'b0;
      exp_pop = RST_PC; exp_req = RST_PC;
      test_reset();
      test_backpressure();
      test_abs_redirect();
      test_rel_redirect();
      test_midreset();
`ifdef IFQ_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front end; the consumer side of the program-counter redirect interface (jmp/rel/diff/nxt semantics).
- Owns the fetch address, issues in-order word reads to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a DEPTH-entry FIFO for decode.
- On redirect, flushes buffered and in-flight fetches and restarts at the new target.

Parameters:
- DEPTH, 4, FIFO entries; also the cap on buffered plus outstanding requests (power of 2, >=2).
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- redir  in  1  redirect request (jmp)
- rel  in  1  1: target = br_pc + diff; 0: target = nxt
- br_pc  in  32  PC of the redirecting instruction
- diff  in  32  relative offset
- nxt  in  32  absolute target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of request
- imem_resp_valid  in  1  response data valid; always accepted
- imem_resp_data  in  32  instruction word
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode consumes
- out_pc  out  32  PC of the head instruction
- out_inst  out  32  head instruction

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: faddr=RESET_PC, rpc=RESET_PC, outstanding=0, drop=0, FIFO empty, out_valid=0, imem_req_valid=0.
- State:
  - faddr: next fetch address.
  - rpc: PC of the next kept response.
  - outstanding: issued requests without a response.
  - drop: responses still to discard.
  - FIFO count.
- imem_req_valid = !redir && (count + outstanding + drop < DEPTH). imem_req_addr = faddr.
  - Request fires when valid && ready.
  - On fire: faddr += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0); outstanding += 1.
- Responses arrive in order, latency >=1 cycle after acceptance.
  - If drop>0: discard and decrement drop.
  - Otherwise push {rpc, data} into the FIFO, rpc += 4, outstanding -= 1.
  - A response while outstanding=0 and drop=0 is ignored.
- Output:
  - out_valid = (count != 0).
  - out_pc/out_inst show the FIFO head, registered with no combinational path from imem_resp.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are both allowed when full; count is unchanged.
- Redirect, applied when redir=1; redir has priority over all same-cycle events:
  - target = rel ? br_pc + diff : nxt (32-bit wrap), with target[1:0] forced to 2'b00.
  - Next cycle: faddr = target, rpc = target, FIFO emptied (a same-cycle pop is a no-op).
  - drop = drop + outstanding, minus 1 if a same-cycle response consumed a drop, or counted toward outstanding if it was a kept response (that response is discarded). Net: every response for a pre-redirect request is discarded.
  - outstanding = 0.
  - No request is issued in the redirect cycle; first new request is at the earliest in the cycle after.
- Back-to-back redirects: last one wins; drop accumulates.
- Throughput: with memory latency 1 and out_ready=1, one instruction per cycle sustained.
- Latency: request accepted at cycle t, response at t+1, out_valid at t+2.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined:
  - When the FIFO is empty, drop=0, redir=0 and imem_resp_valid=1, the response appears combinationally on out_pc/out_inst with out_valid=1 in the same cycle.
  - If out_ready=1 it is consumed without entering the FIFO (rpc and outstanding still update).
  - Latency drops to t+1.
- Not defined: out_* purely registered as above.

Test Plan:
- Reset, memory latency 1, out_ready=1 -> requests at 0x0,0x4,0x8…; out_pc sequence 0x0,0x4,0x8 with out_inst matching; first out_valid 2 cycles after first accept.
- out_ready=0 with DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; raise out_ready -> drains 0x0..0xC in order, fetching resumes at 0x10.
- Absolute redirect nxt=0x100 while 2 requests outstanding and 1 buffered -> FIFO empties, next 2 responses discarded, next out_pc=0x100 then 0x104.
- Relative redirect br_pc=0x20, diff=0xFFFFFFF0, coinciding with a response -> response dropped, no request that cycle, next out_pc=0x10; redirect with nxt=0x103 -> fetch at 0x100.
- Wrap: RESET_PC=0xFFFF_FFF8 -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0; rst asserted mid-stream with 3 outstanding -> out_valid=0 next cycle, fetch restarts at RESET_PC, stale responses ignored.
- IFQ_BYPASS_EN, empty FIFO, response data 0x00000013 -> out_valid=1, out_inst=0x13 same cycle, FIFO count stays 0.
